// File: rtl/conv_arbiter.sv
// ---------------------------------------------------------------------------
// conv_arbiter
//
// Shares one combinational Q16.16 <-> IEEE-754 single-precision converter
// between two requesters. Each requester has a valid/ready handshake, and
// ties are broken round-robin. The accepted operand is registered, converted
// during a single CONV cycle, and the result is registered into resp_data.
// The response is held until the consumer accepts it. Only one conversion is
// in flight at a time.
//
// Optional feature (macro CONV_ARB_STATS_EN):
//   Adds per-requester saturating completion counters conv_count0/1.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   reqN_valid     requester N has an operand                 (N = 0, 1)
//   reqN_ready     requester N operand accepted this cycle
//   reqN_data      requester N operand
//   reqN_to_float  1 = fixed->float, 0 = float->fixed
//   resp_valid     result available
//   resp_ready     consumer accepts result
//   resp_data      converted value
//   resp_id        requester that owns resp_data
//   busy           FSM is not in IDLE
//   conv_count0/1  completed conversions per requester (CONV_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module conv_arbiter #(
    parameter int DATA_W = 32
`ifdef CONV_ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_to_float,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_to_float,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_id,

    output logic              busy
`ifdef CONV_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  conv_count0,
    output logic [CNT_W-1:0]  conv_count1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic [DATA_W-1:0] op_data;
    logic              op_to_float;
    logic              op_id;

    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] conv_result;

    // -----------------------------------------------------------------------
    // Converter core
    // -----------------------------------------------------------------------

    // Q16.16 -> float. The magnitude is normalised so its leading one lands
    // in bit 31; the 23 bits below it are the truncated mantissa.
    function automatic logic [31:0] q_to_float(input logic [31:0] x);
        logic        sign;
        logic [31:0] mag;
        logic [31:0] norm;
        logic [4:0]  msb;
        logic [7:0]  exp;
        logic [22:0] mant;
        sign = x[31];
        mag  = sign ? (~x + 32'd1) : x;
        msb  = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) msb = 5'(i);
        end
        norm = mag << (5'd31 - msb);
        mant = 23'(norm >> 8);
        // 127 + msb - 16, the binary point sits between bits 16 and 15
        exp  = 8'(msb) + 8'd111;
        if (x == 32'd0) begin
            return 32'd0;
        end
        return {sign, exp, mant};
    endfunction

    // float -> Q16.16. The 24-bit significand holds value * 2^23; the fixed
    // result holds value * 2^16, so the net shift is exp - 127 - 23 + 16.
    function automatic logic [31:0] float_to_q(input logic [31:0] f);
        logic        sign;
        logic [7:0]  exp;
        logic [31:0] sig;
        logic [31:0] mag;
        logic [7:0]  sh;
        sign = f[31];
        exp  = f[30:23];
        sig  = {8'd0, 1'b1, f[22:0]};
        if (exp == 8'h00) begin
            return 32'd0;
        end
        if (exp == 8'hFF) begin
            return sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        if (exp >= 8'd134) begin
            sh  = exp - 8'd134;
            mag = sig << sh;
        end else begin
            sh  = 8'd134 - exp;
            mag = sig >> sh;
        end
        return sign ? (~mag + 32'd1) : mag;
    endfunction

    // Long combinational path between the op_* flops and resp_data.
    always_comb begin
        conv_result = op_to_float ? q_to_float(op_data) : float_to_q(op_data);
    end

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------

    // On a tie the port that did not win last time goes next; otherwise the
    // single valid port wins. Ready is additionally qualified with valid so
    // an idle port never sees a stray ready, and is held low during reset.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    assign req0_ready = (state == IDLE) && !rst && req0_valid && (grant == 1'b0);
    assign req1_ready = (state == IDLE) && !rst && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            op_data     <= '0;
            op_to_float <= 1'b0;
            op_id       <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_id     <= 1'b0;
            busy        <= 1'b0;
`ifdef CONV_ARB_STATS_EN
            conv_count0 <= '0;
            conv_count1 <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_data     <= grant ? req1_data     : req0_data;
                        op_to_float <= grant ? req1_to_float : req0_to_float;
                        op_id       <= grant;
                        last_grant  <= grant;
                        busy        <= 1'b1;
                        state       <= CONV;
                    end
                end
                CONV: begin
                    resp_data  <= conv_result;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
`ifdef CONV_ARB_STATS_EN
                        if (!resp_id && (conv_count0 != '1)) conv_count0 <= conv_count0 + 1'b1;
                        if ( resp_id && (conv_count1 != '1)) conv_count1 <= conv_count1 + 1'b1;
`endif
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
